// File: rtl/shift_wb_ctrl.sv
// rtl/shift_wb_ctrl.sv - shift sequencer and register-file writeback arbiter
module shift_wb_ctrl #(
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         shift_op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               ula_wr_req,
  output logic [2:0]         shift_reg_op,
  output logic               MEMtoREG_SELETOR,
  output logic               reg_write,
  output logic               ula_stall,
  output logic               busy,
  output logic               done,
  output logic               op_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  localparam logic [2:0] SR_HOLD = 3'b000;
  localparam logic [2:0] SR_LOAD = 3'b001;
  localparam logic [2:0] SR_SLL  = 3'b010;
  localparam logic [2:0] SR_SRL  = 3'b011;
  localparam logic [2:0] SR_SRA  = 3'b100;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [1:0]         op_r;
  logic [SHAMT_W-1:0] count;
  logic               op_err_r;

  // Sequencer: accept a request in IDLE, load, step shamt times, then write back once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_r     <= OP_SLL;
      count    <= CNT_ZERO;
      op_err_r <= 1'b0;
    end else begin
      op_err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (shift_op == OP_BAD) begin
              op_err_r <= 1'b1;
            end else begin
              op_r  <= shift_op;
              count <= shamt;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          state <= (count != CNT_ZERO) ? SHIFT : WRITE;
        end
        SHIFT: begin
          // Saturate at zero so a corrupted count can never wrap into a long run.
          if (count != CNT_ZERO) begin
            count <= count - CNT_ONE;
          end
          if (count == CNT_ONE || count == CNT_ZERO) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode: shift commands from state/op_r, writeback arbitration with the ULA.
  always_comb begin
    shift_reg_op     = SR_HOLD;
    MEMtoREG_SELETOR = 1'b0;
    ula_stall        = 1'b0;
    busy             = (state != IDLE);
    done             = (state == WRITE);
    op_err           = op_err_r;
    case (state)
      LOAD: begin
        shift_reg_op = SR_LOAD;
      end
      SHIFT: begin
        case (op_r)
          OP_SLL:  shift_reg_op = SR_SLL;
          OP_SRL:  shift_reg_op = SR_SRL;
          OP_SRA:  shift_reg_op = SR_SRA;
          default: shift_reg_op = SR_HOLD;
        endcase
      end
      WRITE: begin
        // Shift result owns the write port; the ULA is told to retry next cycle.
        MEMtoREG_SELETOR = 1'b1;
        ula_stall        = ula_wr_req;
      end
      default: begin
        shift_reg_op = SR_HOLD;
      end
    endcase
    // Gated by reset so a held ULA request cannot write while the block is in reset.
    reg_write = reset_n & ((state == WRITE) | ula_wr_req);
  end

endmodule

// File: tb/tb_shift_wb_ctrl.sv
// tb/tb_shift_wb_ctrl.sv - table-driven scoreboard bench for shift_wb_ctrl
module tb_shift_wb_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] shift_op;
  logic [4:0] shamt;
  logic       ula_wr_req;
  logic [2:0] shift_reg_op;
  logic       MEMtoREG_SELETOR;
  logic       reg_write;
  logic       ula_stall;
  logic       busy;
  logic       done;
  logic       op_err;

  shift_wb_ctrl #(.SHAMT_W(5)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .shift_op         (shift_op),
    .shamt            (shamt),
    .ula_wr_req       (ula_wr_req),
    .shift_reg_op     (shift_reg_op),
    .MEMtoREG_SELETOR (MEMtoREG_SELETOR),
    .reg_write        (reg_write),
    .ula_stall        (ula_stall),
    .busy             (busy),
    .done             (done),
    .op_err           (op_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sro;
    logic       sel;
    logic       rw;
    logic       stall;
    logic       bsy;
    logic       dn;
    logic       err;
  } outv_t;

  typedef struct {
    logic [1:0] op;
    logic [4:0] amt;
    logic       ula;
    int         inj;
    logic [1:0] inj_op;
    logic [2:0] code;
  } vec_t;

  vec_t  vecs[8];
  outv_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic outv_t mk(input logic [2:0] s, input logic sel, input logic rw,
                               input logic stall, input logic bsy, input logic dn,
                               input logic err);
    mk = {s, sel, rw, stall, bsy, dn, err};
  endfunction

  task automatic check(input string name, input outv_t exp);
    outv_t got;
    got = {shift_reg_op, MEMtoREG_SELETOR, reg_write, ula_stall, busy, done, op_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (sro,sel,rw,stall,busy,done,err)", name, got, exp);
    end
  endtask

  task automatic check_pop(input string name);
    outv_t exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=empty_queue exp=entry", name);
    end else begin
      exp = exp_q.pop_front();
      check(name, exp);
    end
  endtask

  // Expected per-cycle trace of one accepted operation, plus two idle cycles after it.
  task automatic push_trace(input logic [2:0] code, input int n, input logic ula);
    exp_q.push_back(mk(3'b001, 1'b0, ula, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk(code, 1'b0, ula, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(3'b000, 1'b1, 1'b1, ula, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(3'b000, 1'b0, ula, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(3'b000, 1'b0, ula, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input string tag);
    start      = 1'b1;
    shift_op   = v.op;
    shamt      = v.amt;
    ula_wr_req = v.ula;
    push_trace(v.code, int'(v.amt), v.ula);
    @(negedge clk);
    start    = 1'b0;
    shift_op = 2'($urandom);
    shamt    = 5'($urandom);
    for (int j = 0; exp_q.size() > 0; j++) begin
      check_pop($sformatf("%s_c%0d", tag, j));
      if (j == v.inj) begin
        start    = 1'b1;
        shift_op = v.inj_op;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start      = 1'b0;
    ula_wr_req = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b00, 5'd3,  1'b0, -1, 2'b00, 3'b010};
    vecs[1] = '{2'b10, 5'd0,  1'b0, -1, 2'b00, 3'b100};
    vecs[2] = '{2'b01, 5'd2,  1'b1, -1, 2'b00, 3'b011};
    vecs[3] = '{2'b10, 5'd5,  1'b0,  2, 2'b01, 3'b100};
    vecs[4] = '{2'b00, 5'd1,  1'b1,  2, 2'b00, 3'b010};
    vecs[5] = '{2'b01, 5'd4,  1'b0,  1, 2'b11, 3'b011};
    vecs[6] = '{2'b10, 5'd31, 1'b1, -1, 2'b00, 3'b100};
    vecs[7] = '{2'b01, 5'd0,  1'b1,  1, 2'b10, 3'b011};

    reset_n    = 1'b0;
    start      = 1'b1;
    shift_op   = 2'b00;
    shamt      = 5'd3;
    ula_wr_req = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    start      = 1'b0;
    ula_wr_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 8; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    start    = 1'b1;
    shift_op = 2'b11;
    shamt    = 5'd7;
    exp_q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check_pop($sformatf("op_err_c%0d", j));
      @(negedge clk);
    end

    start      = 1'b1;
    shift_op   = 2'b00;
    shamt      = 5'd31;
    ula_wr_req = 1'b0;
    exp_q.push_back(mk(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 7; k++)
      exp_q.push_back(mk(3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check_pop($sformatf("long_sll_c%0d", j));
      @(negedge clk);
    end
    #1 reset_n = 1'b0;
    #1 check("reset_mid_shift_async", mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    ula_wr_req = 1'b1;
    @(negedge clk);
    check("reset_held_ula_gated", mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    ula_wr_req = 1'b0;
    reset_n    = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("post_abort_idle_%0d", j), mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    run_vec('{2'b01, 5'd2, 1'b0, -1, 2'b00, 3'b011}, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_wb_ctrl.md
SHIFT_WB_CTRL -- requirements
Module: shift_wb_ctrl

Interface
REQ-001 Parameter SHAMT_W, default 5, width of shift amount and internal down-counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a shift operation; sampled only in IDLE.
REQ-005 shift_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 invalid.
REQ-006 shamt  input  SHAMT_W  number of 1-bit shift steps.
REQ-007 ula_wr_req  input  1  ULA result ready for register-file writeback; upstream holds it high until accepted.
REQ-008 shift_reg_op  output  3  command to shift register: 000 hold, 001 load, 010 shift left 1, 011 shift right logical 1, 100 shift right arithmetic 1.
REQ-009 MEMtoREG_SELETOR  output  1  writeback mux select: 0 ULA output, 1 shift register output.
REQ-010 reg_write  output  1  register-file write enable.
REQ-011 ula_stall  output  1  ULA writeback refused this cycle.
REQ-012 busy  output  1  high in LOAD, SHIFT, WRITE.
REQ-013 done  output  1  one-cycle pulse in WRITE.
REQ-014 op_err  output  1  one-cycle pulse when start arrives with shift_op=11 in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT, WRITE; all outputs decoded from current state, registered op/count, and ula_wr_req.
REQ-016 IDLE: start=1 and shift_op!=11 -> latch shift_op and shamt into op_r/count, next LOAD; otherwise stay IDLE.
REQ-017 IDLE: start=1 and shift_op=11 -> op_err=1 next cycle for exactly one cycle, state stays IDLE, nothing latched.
REQ-018 LOAD: shift_reg_op=001 for exactly one cycle; next SHIFT if count!=0, else WRITE.
REQ-019 SHIFT: shift_reg_op = 010/011/100 for op_r SLL/SRL/SRA; count decrements each cycle; count==1 -> next WRITE.
REQ-020 SHIFT SHALL last exactly shamt cycles; count never wraps below 0.
REQ-021 WRITE: MEMtoREG_SELETOR=1, reg_write=1, done=1, shift_reg_op=000; next IDLE.
REQ-022 Latency: start accepted at edge T -> LOAD in cycle T+1, WRITE in cycle T+2+shamt (shamt=0: T+2).
REQ-023 start while busy=1 SHALL be ignored (not queued), including in WRITE.
REQ-024 shamt/shift_op changes after acceptance SHALL not affect the operation in flight.
REQ-025 Outside WRITE: ula_wr_req=1 -> reg_write=1, MEMtoREG_SELETOR=0, ula_stall=0; ula_wr_req=0 -> reg_write=0.
REQ-026 In WRITE with ula_wr_req=1 (simultaneous event): shift result wins, ula_stall=1, ULA write occurs next cycle (IDLE) if request still held.
REQ-027 shift_reg_op=000 in IDLE and WRITE; MEMtoREG_SELETOR=0 in every state except WRITE.
REQ-028 At most one register-file write per cycle; reg_write never asserted without a defined MEMtoREG_SELETOR source.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, op_r=00, count=0, op_err flag cleared, independent of clk.
REQ-030 During reset all outputs 0: shift_reg_op=000, MEMtoREG_SELETOR=0, reg_write=0, ula_stall=0, busy=0, done=0, op_err=0.
REQ-031 Reset mid-operation (LOAD/SHIFT/WRITE) SHALL abort with no shift writeback; after release, first start is accepted normally.

Verification
REQ-032 start, SLL, shamt=3 at edge T -> LOAD at T+1 (op 001), 010 for T+2..T+4, WRITE at T+5 (sel=1, reg_write=1, done=1), IDLE at T+6.
REQ-033 start, SRA, shamt=0 -> LOAD one cycle, WRITE next, zero shift cycles, shift_reg_op never 100.
REQ-034 SRL shamt=2 with ula_wr_req held 1 throughout -> reg_write=1 sel=0 every non-WRITE cycle; in WRITE ula_stall=1, sel=1; next cycle sel=0, reg_write=1, ula_stall=0.
REQ-035 shift_op=11 with start in IDLE -> op_err pulses one cycle, busy stays 0; start pulsed during SHIFT -> ignored, exactly one done.
REQ-036 SLL shamt=31 (SHAMT_W=5), reset_n pulled low mid-SHIFT between edges -> outputs 0 immediately, no done, no reg_write until new start.
